// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite row fetcher and its line buffer.
package sprite_pkg;

   localparam int unsigned SPRITE_W  = 32;
   localparam int unsigned SPRITE_H  = 32;
   localparam int unsigned PALETTE_W = 3;

   typedef logic [PALETTE_W-1:0] palette_idx_t;

   typedef enum logic [2:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t;

endpackage

// File: rtl/sprite_line_buffer.sv
// Two-bank ping-pong line buffer: one synchronous write port, one combinational read port.
module sprite_line_buffer #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned DATA_W = 3
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic                     wr_bank_i,
   input  logic [$clog2(WIDTH)-1:0] wr_idx_i,
   input  logic [DATA_W-1:0]        wr_data_i,
   input  logic                     rd_bank_i,
   input  logic [$clog2(WIDTH)-1:0] rd_idx_i,
   output logic [DATA_W-1:0]        rd_data_o
);
   import sprite_pkg::*;

   logic [DATA_W-1:0] mem_q [2][WIDTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wr_bank_i][wr_idx_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_bank_i][rd_idx_i];

endmodule

// File: rtl/sprite_row_fetcher.sv
// Fetches one sprite row from ROM during blanking into a ping-pong buffer and
// serves registered palette indices keyed on draw_x during active video.
module sprite_row_fetcher #(
   parameter int unsigned SPRITE_W    = sprite_pkg::SPRITE_W,
   parameter int unsigned SPRITE_H    = sprite_pkg::SPRITE_H,
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned DATA_W      = 3,
   parameter int unsigned TRANSPARENT = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic [9:0]        next_line_y,
   input  logic [9:0]        sprite_x,
   input  logic [9:0]        sprite_y,
   input  logic              flip_h,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic              busy,
   output logic              done,
   input  logic [9:0]        draw_x,
   output logic              pixel_valid,
   output logic [DATA_W-1:0] pixel_idx
);
   import sprite_pkg::*;

   localparam int unsigned COL_W = $clog2(SPRITE_W);
   localparam int unsigned ROW_W = $clog2(SPRITE_H);

   fetch_state_t      state_q, state_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic              flip_q, flip_d;
   logic              pend_hit_q, pend_hit_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              read_bank_q, read_bank_d;
   logic [1:0]        hit_q, hit_d;
   logic              cap_valid_q, cap_valid_d;
   logic [COL_W-1:0]  cap_idx_q, cap_idx_d;
   logic              pixel_valid_q, pixel_valid_d;
   logic [DATA_W-1:0] pixel_idx_q, pixel_idx_d;

   logic [10:0]       row_diff, off;
   logic              row_hit, off_in;
   logic              write_bank;
   logic [DATA_W-1:0] rd_data;

   function automatic logic [ADDR_W-1:0] row_addr(input logic [ROW_W-1:0] r,
                                                  input logic [COL_W-1:0] c);
      return ADDR_W'(r) * ADDR_W'(SPRITE_W) + ADDR_W'(c);
   endfunction

   // 11-bit differences keep negative offsets/rows from aliasing into range.
   assign row_diff   = {1'b0, next_line_y} - {1'b0, sprite_y};
   assign row_hit    = !row_diff[10] && (row_diff < 11'(SPRITE_H));
   assign off        = {1'b0, draw_x} - {1'b0, sprite_x};
   assign off_in     = !off[10] && (off < 11'(SPRITE_W));
   assign write_bank = ~read_bank_q;

   sprite_line_buffer #(
      .WIDTH  (SPRITE_W),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk_i     (clock),
      .we_i      (cap_valid_q),
      .wr_bank_i (write_bank),
      .wr_idx_i  (cap_idx_q),
      .wr_data_i (rom_q),
      .rd_bank_i (read_bank_q),
      .rd_idx_i  (off[COL_W-1:0]),
      .rd_data_o (rd_data)
   );

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      col_d       = col_q;
      flip_d      = flip_q;
      pend_hit_d  = pend_hit_q;
      rom_addr_d  = rom_addr_q;
      read_bank_d = read_bank_q;
      hit_d       = hit_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (row_hit) begin
                  row_d      = row_diff[ROW_W-1:0];
                  flip_d     = flip_h;
                  col_d      = '0;
                  pend_hit_d = 1'b1;
                  rom_addr_d = row_addr(row_diff[ROW_W-1:0], '0);
                  state_d    = FETCH;
               end else begin
                  pend_hit_d = 1'b0;
                  state_d    = DONE;
               end
            end
         end
         FETCH: begin
            if (col_q == COL_W'(SPRITE_W - 1)) begin
               state_d = DRAIN;
            end else begin
               col_d      = col_q + 1'b1;
               rom_addr_d = row_addr(row_q, col_d);
            end
         end
         DRAIN: state_d = DONE;
         DONE: begin
            read_bank_d       = write_bank;
            hit_d[write_bank] = pend_hit_q;
            state_d           = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // rom_q for the address issued this cycle arrives next cycle.
      cap_valid_d = (state_q == FETCH);
      cap_idx_d   = flip_q ? COL_W'(SPRITE_W - 1) - col_q : col_q;

      pixel_valid_d = hit_q[read_bank_q] && off_in && (rd_data != DATA_W'(TRANSPARENT));
      pixel_idx_d   = pixel_valid_d ? rd_data : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= IDLE;
         row_q         <= '0;
         col_q         <= '0;
         flip_q        <= 1'b0;
         pend_hit_q    <= 1'b0;
         rom_addr_q    <= '0;
         read_bank_q   <= 1'b0;
         hit_q         <= '0;
         cap_valid_q   <= 1'b0;
         cap_idx_q     <= '0;
         pixel_valid_q <= 1'b0;
         pixel_idx_q   <= '0;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         flip_q        <= flip_d;
         pend_hit_q    <= pend_hit_d;
         rom_addr_q    <= rom_addr_d;
         read_bank_q   <= read_bank_d;
         hit_q         <= hit_d;
         cap_valid_q   <= cap_valid_d;
         cap_idx_q     <= cap_idx_d;
         pixel_valid_q <= pixel_valid_d;
         pixel_idx_q   <= pixel_idx_d;
      end
   end

   assign rom_addr    = rom_addr_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign pixel_valid = pixel_valid_q;
   assign pixel_idx   = pixel_idx_q;

endmodule

// File: tb/tb_sprite_row_fetcher.sv
// Bench for sprite_row_fetcher: directed scenarios plus random traffic against a line-level model.
module tb_sprite_row_fetcher;
   import sprite_pkg::*;

   localparam int W = 32;
   localparam int H = 32;

   logic         clock = 1'b0;
   logic         reset, start, flip_h;
   logic [9:0]   next_line_y, sprite_x, sprite_y, draw_x;
   logic [9:0]   rom_addr;
   palette_idx_t rom_q;
   logic         busy, done, pixel_valid;
   palette_idx_t pixel_idx;

   palette_idx_t rom_mem [1024];

   always #5 clock = ~clock;
   always @(posedge clock) rom_q <= rom_mem[rom_addr];

   sprite_row_fetcher #(
      .SPRITE_W    (32),
      .SPRITE_H    (32),
      .ADDR_W      (10),
      .DATA_W      (3),
      .TRANSPARENT (0)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .next_line_y (next_line_y),
      .sprite_x    (sprite_x),
      .sprite_y    (sprite_y),
      .flip_h      (flip_h),
      .rom_addr    (rom_addr),
      .rom_q       (rom_q),
      .busy        (busy),
      .done        (done),
      .draw_x      (draw_x),
      .pixel_valid (pixel_valid),
      .pixel_idx   (pixel_idx)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: the row currently on display and the row being prepared, as pixel arrays.
   bit active, acc_hit, disp_hit, pend_hit, exp_pv;
   int acc_cyc, done_at, acc_base, exp_pi, exp_addr;
   int disp_line [W];
   int pend_line [W];

   task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      int  off, r;
      bit  npv;
      int  npi;
      if (active && acc_hit && cyc >= acc_cyc + 1 && cyc <= acc_cyc + W)
         exp_addr = acc_base + (cyc - acc_cyc - 1);
      check_eq("busy", busy, active && cyc > acc_cyc);
      check_eq("done", done, active && cyc == done_at);
      check_eq("rom_addr", rom_addr, exp_addr);
      check_eq("pix_valid", pixel_valid, exp_pv);
      check_eq("pix_idx", pixel_idx, exp_pi);

      off = int'(draw_x) - int'(sprite_x);
      npv = disp_hit && off >= 0 && off < W && disp_line[off] != 0;
      npi = npv ? disp_line[off] : 0;

      if (reset) begin
         active   = 1'b0;
         disp_hit = 1'b0;
         npv      = 1'b0;
         npi      = 0;
         exp_addr = 0;
      end else if (!active && start) begin
         r        = int'(next_line_y) - int'(sprite_y);
         acc_hit  = r >= 0 && r < H;
         pend_hit = acc_hit;
         acc_cyc  = cyc;
         acc_base = r * W;
         done_at  = cyc + (acc_hit ? W + 2 : 1);
         if (acc_hit)
            for (int c = 0; c < W; c++)
               pend_line[c] = int'(rom_mem[r * W + (flip_h ? W - 1 - c : c)]);
         active = 1'b1;
      end else if (active && cyc == done_at) begin
         disp_hit  = pend_hit;
         disp_line = pend_line;
         active    = 1'b0;
      end

      @(posedge clock);
      #1;
      cyc++;
      exp_pv = npv;
      exp_pi = npi;
      start  = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         draw_x = 10'(int'(sprite_x) + int'($urandom_range(0, 40)) - 4);
         step();
      end
   endtask

   task automatic probe(input int dx);
      draw_x = 10'(int'(sprite_x) + dx);
      step();
   endtask

   task automatic launch(input int nly, input bit flip);
      next_line_y = 10'(nly);
      flip_h      = flip;
      start       = 1'b1;
      draw_x      = sprite_x;
      step();
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; flip_h = 1'b0;
      next_line_y = '0; sprite_x = 10'd200; sprite_y = 10'd100; draw_x = '0;
      for (int a = 0; a < 1024; a++) begin
         logic [9:0] av;
         av         = 10'(a);
         rom_mem[a] = av[2:0];
      end
      active = 0; disp_hit = 0; exp_pv = 0; exp_pi = 0; exp_addr = 0;
      acc_cyc = 0; done_at = 0; acc_hit = 0; pend_hit = 0; acc_base = 0;
      repeat (2) @(posedge clock);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_addr", rom_addr, 0);
      check_eq("rst_pv", pixel_valid, 0);
      check_eq("rst_pi", pixel_idx, 0);
      reset = 1'b0;

      // Hit, no flip
      launch(105, 1'b0);
      check_eq("s1_addr_c1", rom_addr, 160);
      run(31);
      check_eq("s1_addr_c32", rom_addr, 191);
      run(2);
      check_eq("s1_done_c34", done, 1);
      run(1);
      probe(3);
      check_eq("s1_pv", pixel_valid, 1);
      check_eq("s1_pi", pixel_idx, 3);

      // Flip
      launch(105, 1'b1);
      run(34);
      probe(0);
      check_eq("s2_pv_l", pixel_valid, 1);
      check_eq("s2_pi_l", pixel_idx, 7);
      probe(31);
      check_eq("s2_pv_r", pixel_valid, 0);
      check_eq("s2_pi_r", pixel_idx, 0);

      // Transparency and horizontal edges
      launch(105, 1'b0);
      run(34);
      probe(8);
      check_eq("s3_transp", pixel_valid, 0);
      probe(-1);
      check_eq("s3_left", pixel_valid, 0);
      probe(32);
      check_eq("s3_right", pixel_valid, 0);
      probe(31);
      check_eq("s3_last", pixel_idx, 7);

      // Vertical bounds
      launch(131, 1'b0);
      check_eq("s4_addr_lo", rom_addr, 992);
      run(31);
      check_eq("s4_addr_hi", rom_addr, 1023);
      run(3);
      launch(132, 1'b0);
      check_eq("s4_below_done", done, 1);
      check_eq("s4_below_addr", rom_addr, 1023);
      for (int d = -4; d < 40; d++) probe(d);
      launch(99, 1'b0);
      check_eq("s4_above_done", done, 1);
      check_eq("s4_above_addr", rom_addr, 1023);
      for (int d = -4; d < 40; d++) probe(d);

      // Ping-pong with distinct row contents
      for (int a = 0; a < 1024; a++) rom_mem[a] = palette_idx_t'($urandom_range(0, 7));
      launch(105, 1'b0);
      run(36);
      launch(106, 1'b0);
      for (int d = 0; d < 33; d++) probe(d);
      run(4);
      for (int d = 0; d < 33; d++) probe(d);

      // Start re-pulsed mid-fetch, then reset mid-fetch
      launch(110, 1'b0);
      run(4);
      next_line_y = 10'd120;
      start = 1'b1;
      step();
      run(28);
      check_eq("s6_done_c34", done, 1);
      run(2);
      launch(111, 1'b1);
      run(9);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("s6_rst_busy", busy, 0);
      check_eq("s6_rst_pv", pixel_valid, 0);
      run(40);

      // Random traffic
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 99) == 0) sprite_x = 10'($urandom_range(0, 1023));
         reset = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 7) == 0) begin
            sprite_y    = 10'($urandom_range(0, 1023));
            next_line_y = 10'(int'(sprite_y) + int'($urandom_range(0, 36)) - 2);
            flip_h      = 1'($urandom_range(0, 1));
            start       = 1'b1;
         end
         if ($urandom_range(0, 3) == 0)
            draw_x = 10'($urandom_range(0, 1023));
         else
            draw_x = 10'(int'(sprite_x) + int'($urandom_range(0, 40)) - 4);
         step();
      end
      reset = 1'b0;
      run(40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sprite_row_fetcher.md
Name: sprite_row_fetcher

Overview:
- Read-side client for the 32x32 sprite ROMs. Each ROM has a 10-bit address, a registered q and 1-cycle read latency.
- On a start pulse during horizontal blanking, the block fetches one sprite row into a ping-pong line buffer, with optional horizontal flip.
- During active video it serves palette indices keyed on DrawX.
- Sits between the VGA controller and the colour mapper, one instance per on-screen sprite.

Parameters:
- SPRITE_W, 32, sprite width in pixels.
- SPRITE_H, 32, sprite height in rows.
- ADDR_W, 10, ROM address width; must equal log2(SPRITE_W*SPRITE_H).
- DATA_W, 3, palette index width; 3 or 4.
- TRANSPARENT, 0, palette index treated as see-through.

Ports:
- clock, in, 1, system clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle pulse requesting a fetch for next_line_y.
- next_line_y, in, 10, scanline to be prepared.
- sprite_x, in, 10, sprite left edge; sampled continuously.
- sprite_y, in, 10, sprite top edge; sampled at start.
- flip_h, in, 1, mirror the row horizontally; sampled at start.
- rom_addr, out, ADDR_W, registered address to the sprite ROM.
- rom_q, in, DATA_W, ROM data, valid 1 cycle after rom_addr.
- busy, out, 1, high from the cycle after an accepted start until done.
- done, out, 1, one-cycle pulse when the fetched row becomes readable.
- draw_x, in, 10, current pixel column.
- pixel_valid, out, 1, registered; opaque sprite pixel at the draw_x sampled one cycle earlier.
- pixel_idx, out, DATA_W, registered palette index; 0 when pixel_valid is 0.

Behaviour:
- Reset: all of the following are cleared or set to 0:
  - state = IDLE; rom_addr, busy, done, pixel_valid, pixel_idx.
  - read_bank, hit[0], hit[1].
  - Buffer contents are don't-care.
- Reset asserted mid-fetch aborts the fetch: no done pulse, and busy is 0 on the following cycle.
- Row computation at start: row = next_line_y - sprite_y, computed 11-bit signed. The row is a hit iff 0 <= row < SPRITE_H.
- start is accepted only in IDLE. A start while busy is ignored and does not queue.
- State machine:
  - IDLE, start on a hit: latch row and flip_h, col = 0, go to FETCH.
  - IDLE, start on a miss: go to DONE with a pending hit flag of 0. No ROM activity occurs and rom_addr holds its value.
  - FETCH, cycles 1..SPRITE_W after start: rom_addr = row*SPRITE_W + col, col incrementing 0..SPRITE_W-1. After col = SPRITE_W-1, go to DRAIN.
  - DRAIN, 1 cycle: captures the final rom_q. Then go to DONE.
  - DONE, 1 cycle: pulse done, toggle read_bank, set hit[new read_bank] = pending hit flag, go to IDLE.
- Timing, start sampled at cycle 0:
  - Hit: done at cycle SPRITE_W+2 (34 with defaults).
  - Miss: done at cycle 1.
  - busy is high from cycle 1 through the done cycle inclusive.
- Data path: rom_q arriving for column c is written to write_bank = ~read_bank, at index c, or SPRITE_W-1-c when flip_h.
- Read path, registered with 1-cycle latency:
  - off = draw_x - sprite_x, computed 11-bit signed.
  - pixel_valid <= hit[read_bank] && 0 <= off < SPRITE_W && buf[read_bank][off] != TRANSPARENT.
  - pixel_idx <= the stored index if pixel_valid, else 0.
- Reads from read_bank are unaffected by concurrent writes to write_bank. The bank swap takes effect for draw_x sampled in the cycle after done.
- Wrap-around: negative or out-of-range off and row values never alias into the buffer.

Decomposition:
- sprite_pkg holds:
  - Constants SPRITE_W, SPRITE_H.
  - typedef enum logic [2:0] {IDLE, FETCH, DRAIN, DONE} fetch_state_t.
  - typedef for the palette index.
- One sub-module, sprite_line_buffer: two banks of SPRITE_W x DATA_W, one write port (bank, index, data, we) and one read port (bank, index). The read port is combinational; the output register lives in the parent.

Test Plan:
1. Hit, no flip: ROM model q = addr[2:0], sprite_y=100, next_line_y=105, start at cycle 0.
   -> rom_addr = 160..191 on cycles 1..32, done at cycle 34.
   -> Then draw_x = sprite_x+3 gives pixel_valid=1, pixel_idx=3 one cycle later.
2. Flip: same as scenario 1 with flip_h=1.
   -> draw_x = sprite_x gives pixel_idx=7 (column 31, addr 191).
   -> draw_x = sprite_x+31 gives pixel_idx=0 with pixel_valid=0 (addr 160 is transparent).
3. Transparency and edges, scenario 1 data.
   -> Offset 8 (addr 168, q=0) gives pixel_valid=0.
   -> draw_x = sprite_x-1 and draw_x = sprite_x+32 both give pixel_valid=0.
4. Vertical bounds.
   -> next_line_y = sprite_y+31 is a hit (rom_addr 992..1023).
   -> next_line_y = sprite_y+32 and next_line_y = sprite_y-1 are misses: done at cycle 1, rom_addr unchanged, pixel_valid=0 for the whole line.
5. Ping-pong: fetch row 5 and let done swap banks, then start a fetch for row 6.
   -> During the row-6 fetch, reads still return row-5 data.
   -> After the row-6 done, reads return row-6 data.
6. Protocol robustness: start re-pulsed at cycle 5 of a fetch.
   -> Ignored; done still at cycle 34.
   -> reset at cycle 10 of a new fetch gives busy=0 and pixel_valid=0 on the next cycle, and no done pulse.
